// File: rtl/serial_addsub32.sv
// serial_addsub32 -- digit-serial adder/subtractor.
//
// Computes a+b (sub=0) or a-b (sub=1) over WIDTH bits, DIGIT bits per clock,
// so an operation takes N = WIDTH/DIGIT RUN cycles plus one DONE cycle.
// Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, sub      request / operation select (sampled only while busy=0)
//   a, b            operands (sampled with start)
//   busy            high from the cycle after acceptance through the done cycle
//   done            one-cycle pulse; result and flags valid
//   result          sum/difference mod 2^WIDTH (changes only on entry to DONE)
//   cout            carry out of MSB (for sub: 1 = no borrow)
//   overflow        two's-complement signed overflow
//   zero            result == 0 (only when ADDSUB_ZERO_FLAG_EN is defined)
//
// Build option: define ADDSUB_ZERO_FLAG_EN to add the zero output.
module serial_addsub32 #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef ADDSUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = WIDTH - DIGIT;   // shadow holds all digits but the last
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % DIGIT) != 0 || N < 2) begin : g_param_check
        $error("serial_addsub32: DIGIT must divide WIDTH with at least two digits");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  areg;     // operands shift right one digit per RUN cycle
    logic [WIDTH-1:0]  breg;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     shadow;   // completed digits, filled from the top down

    logic [DIGIT:0]    dsum;
    logic [WIDTH-1:0]  shadow_nxt;

    // Current digit always sits in the low DIGIT bits of the shifted operands.
    assign dsum = {1'b0, areg[DIGIT-1:0]} + {1'b0, breg[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};
    // After the last digit this is the full result, in place.
    assign shadow_nxt = {dsum[DIGIT-1:0], shadow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            areg     <= '0;
            breg     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            shadow   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
            zero     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        areg  <= a;
                        breg  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    areg   <= areg >> DIGIT;
                    breg   <= breg >> DIGIT;
                    carry  <= dsum[DIGIT];
                    shadow <= shadow_nxt[WIDTH-1:DIGIT];
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Low digit of areg/breg now holds the original MSBs.
                        result   <= shadow_nxt;
                        cout     <= dsum[DIGIT];
                        overflow <= (areg[DIGIT-1] == breg[DIGIT-1]) &&
                                    (dsum[DIGIT-1] != areg[DIGIT-1]);
`ifdef ADDSUB_ZERO_FLAG_EN
                        zero     <= (shadow_nxt == '0);
`endif
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
